// File: rtl/serial_add16.sv
// Nibble-serial adder/subtractor: one 4-bit adder reused over NIB cycles.
// Carry ripples between nibbles only through a register.

module fouradder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

module serial_add16 #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [4*NIB-1:0] A,
    input  logic [4*NIB-1:0] B,
    input  logic             Cin,
    output logic [4*NIB-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next;

    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry;
    logic [IW-1:0] idx;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    sum;
    logic          co;
    logic          last;
    logic          accept;

    assign last   = (idx == IW'(NIB - 1));
    assign accept = start && (state != RUN);
    assign nib_a  = a_r[{idx, 2'b00} +: 4];
    assign nib_b  = b_r[{idx, 2'b00} +: 4];
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    fouradder u_add (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry),
        .s  (sum),
        .co (co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state: accept from IDLE/DONE, run NIB cycles, then report
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = start ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = start ? RUN : IDLE;
            default: next = IDLE;
        endcase
    end

    // Operand latch and per-nibble result/carry update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_r   <= A;
            b_r   <= B ^ {W{sub}};
            carry <= sub ? 1'b1 : Cin;
            idx   <= '0;
        end else if (state == RUN) begin
            S[{idx, 2'b00} +: 4] <= sum;
            carry <= co;
            idx   <= idx + 1'b1;
            if (last) begin
                Cout <= co;
                ovf  <= (a_r[W-1] == b_r[W-1]) && (sum[3] != a_r[W-1]);
            end
        end
    end

endmodule

// File: tb/tb_serial_add16.sv
// Scoreboard bench for serial_add16: directed vectors,
// monitor pops expected results on every done pulse.

module tb_serial_add16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] S;
    logic        Cout;
    logic        ovf;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    serial_add16 #(.NIB(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .S     (S),
        .Cout  (Cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("S", {16'd0, S}, {16'd0, e.s});
                check("Cout", {31'd0, Cout}, {31'd0, e.co});
                check("ovf", {31'd0, ovf}, {31'd0, e.ov});
                check("latency", cyc - e.acc, 32'd4);
            end
        end
    end

    task automatic op(input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb_in,
                      input logic [15:0] es, input logic eco,
                      input logic eov);
        exp_t e;
        A = a;
        B = b;
        Cin = ci;
        sub = sb_in;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.s = es;
        e.co = eco;
        e.ov = eov;
        e.acc = cyc;
        sb.push_back(e);
        repeat (4) begin
            @(negedge clk);
            check("busy_run", {31'd0, busy}, 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        sub = 1'b0;
        A = 16'h0;
        B = 16'h0;
        Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_S", {16'd0, S}, 32'd0);
        check("rst_Cout", {31'd0, Cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;

        op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Hold: inputs wiggle with start low, outputs must stay put
        for (int i = 0; i < 10; i++) begin
            A = 16'($urandom);
            B = 16'($urandom);
            Cin = 1'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
            check("hold_S", {16'd0, S}, 32'h7FFF);
            check("hold_Cout", {31'd0, Cout}, 32'd1);
            check("hold_ovf", {31'd0, ovf}, 32'd1);
            check("hold_busy", {31'd0, busy}, 32'd0);
            check("hold_done", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Back-to-back with start held; operands scrambled during RUN
        A = 16'h0102;
        B = 16'h0304;
        Cin = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            e.s = 16'h0406;
            e.co = 1'b0;
            e.ov = 1'b0;
            e.acc = cyc;
            sb.push_back(e);
            A = 16'hFFFF;
            B = 16'hAAAA;
            Cin = 1'b1;
            sub = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            A = 16'h0102;
            B = 16'h0304;
            Cin = 1'b0;
            sub = 1'b0;
            if (k == 2) start = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset at the second RUN edge aborts with no done pulse
        A = 16'h1111;
        B = 16'h2222;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_S", {16'd0, S}, 32'd0);
        check("abort_Cout", {31'd0, Cout}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
